gaussian_blur_separable: RTL and testbench
==========================================

GAUSSIAN_BLUR_SEPARABLE -- requirements
Module: gaussian_blur_separable

Interface
REQ-001 SHALL provide parameter WIDTH, default 640, image width in pixels.
REQ-002 SHALL provide parameter HEIGHT, default 480, image height in lines.
REQ-003 SHALL provide parameter XBITS, default 10, x-coordinate width; YBITS, default 9, y-coordinate width.
REQ-004 SHALL provide parameters K0 (default 1), K1 (default 4) and K2 (default 6), the coefficients of the symmetric 5-tap kernel K0,K1,K2,K1,K0.
REQ-005 SHALL provide parameter SHIFT, default 4, the normalisation right-shift; the coefficient sum is nominally 2^SHIFT.
REQ-006 SHALL provide parameter READ_LATENCY, default 1, range 1-3, the cycles from read_addr to valid read_data.
REQ-007 SHALL provide ports clk (input, 1 bit, sole clock) and reset (input, 1 bit, synchronous active-high reset).
REQ-008 SHALL provide start (input, 1 bit, single-cycle frame-start pulse).
REQ-009 SHALL provide direction (input, 1 bit, 0 = horizontal pass, 1 = vertical pass) and channel (input, 2 bits, 0 = bits[29:20], 1 = [19:10], 2 = [9:0], 3 reserved and treated as 0).
REQ-010 SHALL provide gray (input, 1 bit); when 1, the non-selected channels are written as 512, otherwise they pass through from the centre tap.
REQ-011 SHALL provide busy (output, 1 bit, frame in progress) and done (output, 1 bit, single-cycle completion pulse).
REQ-012 SHALL provide read_addr (output, XBITS+YBITS bits) and read_data (input, 36 bits).
REQ-013 SHALL provide write_addr (output, XBITS+YBITS bits), write_data (output, 36 bits) and write_enable (output, 1 bit).
REQ-014 SHALL form every address as {y, x}, i.e. y*2^XBITS + x.

Function
REQ-015 SHALL sample direction, channel and gray on the start cycle and hold them constant for the whole frame.
REQ-016 SHALL implement states IDLE, READ, WAIT, WRITE and FINISH.
- IDLE -start-> READ.
- READ lasts 5 cycles, tap k = 0..4 issued in READ cycle k.
- WAIT lasts READ_LATENCY cycles.
- WRITE lasts 1 cycle, then READ for the next pixel, or FINISH after pixel (WIDTH-1, HEIGHT-1).
- FINISH lasts 1 cycle, then IDLE.
REQ-017 SHALL issue, for tap k of pixel (x,y), address (clamp(x+k-2), y) in horizontal mode or (x, clamp(y+k-2)) in vertical mode; clamp limits to 0..WIDTH-1 or 0..HEIGHT-1.
REQ-018 SHALL accumulate coef(k) * selected 10-bit field of read_data exactly READ_LATENCY cycles after tap k is issued; the accumulator is at least 10+SHIFT+3 bits wide and is cleared at the start of each pixel.
REQ-019 SHALL capture the full 36-bit read_data word returned for tap 2 (the centre tap) as the pass-through word.
REQ-020 SHALL compute result = (acc + 2^(SHIFT-1)) >> SHIFT, saturated to 1023.
REQ-021 SHALL, in WRITE, drive write_enable=1 and write_addr={y,x}, with write_data[35:30]=0, the selected field = result, and the other fields = 512 (gray=1) or the centre-word fields (gray=0).
REQ-022 SHALL hold write_enable=0 in every state except WRITE.
REQ-023 SHALL process pixels in raster order (x fastest); the per-pixel period is exactly 6+READ_LATENCY cycles.
REQ-024 SHALL hold busy=1 from the cycle after start through FINISH inclusive.
REQ-025 SHALL assert done for exactly the one FINISH cycle, i.e. the cycle after the final WRITE.
REQ-026 SHALL, on start while busy, abandon the frame without done and restart at pixel (0,0) with the newly sampled modes.
REQ-027 SHALL ignore data returning from taps issued before a restart; no such data reaches the accumulator.
REQ-028 SHALL give reset priority over start when both are asserted in the same cycle.

Reset
REQ-029 SHALL, on reset, enter IDLE and drive busy=0, done=0, write_enable=0, read_addr=0, write_addr=0, write_data=0, clear the accumulator and x/y counters, and flush in-flight tap tracking.
REQ-030 SHALL, on reset mid-frame, produce no further writes and no done pulse.

Verification
REQ-031 SHALL pass the constant-frame test: WIDTH=8, HEIGHT=4, all channel-0 values 100, horizontal, gray=1 -> 32 writes, each {6'b0,100,512,512}; done exactly 1 cycle after the 32nd write.
REQ-032 SHALL pass the horizontal impulse test: channel 0 = 1023 at (3,1), 0 elsewhere -> row 1, x=1..5 yield 64,256,384,256,64; all other pixels yield 0.
REQ-033 SHALL pass the vertical impulse test: same image, direction=1 -> column 3 at y=0 yields 256 (rows -1 and 0 clamp to 0), y=1 yields 384, y=2 yields 256, y=3 yields 64; all other pixels yield 0.
REQ-034 SHALL pass the edge-clamp and pass-through test: row 0 channel-1 values 0,16,32,... with channel=1, gray=0 -> pixel (0,0) field[19:10]=6, and fields [29:20] and [9:0] equal the stored (0,0) word.
REQ-035 SHALL pass the timing test: READ_LATENCY=2 -> write_enable pulses exactly every 8 cycles; READ_LATENCY=3 -> every 9 cycles.
REQ-036 SHALL pass the reset/restart test:
- Reset asserted after 10 writes -> IDLE within 1 cycle, no done, write_enable stays 0.
- start re-pulsed mid-frame -> next write targets address 0, and exactly one done pulse follows the completed restarted frame.

Source files
------------

// File: rtl/gaussian_blur_separable_if.sv
// Frame-control, tap-read and result-write signals of the separable Gaussian blur engine.
interface gaussian_blur_separable_if #(
  parameter int AW = 19
);
  logic          start;
  logic          direction;
  logic [1:0]    channel;
  logic          gray;
  logic          busy;
  logic          done;
  logic [AW-1:0] read_addr;
  logic [35:0]   read_data;
  logic [AW-1:0] write_addr;
  logic [35:0]   write_data;
  logic          write_enable;

  modport master (
    output start, direction, channel, gray, read_data,
    input  busy, done, read_addr, write_addr, write_data, write_enable
  );

  modport slave (
    input  start, direction, channel, gray, read_data,
    output busy, done, read_addr, write_addr, write_data, write_enable
  );
endinterface

// File: rtl/gaussian_blur_separable.sv
// One-dimensional 5-tap Gaussian pass (horizontal or vertical) over one 10-bit channel
// of a 36-bit-per-pixel frame, one pixel at a time in raster order.
module gaussian_blur_separable #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int XBITS        = 10,
  parameter int YBITS        = 9,
  parameter int K0           = 1,
  parameter int K1           = 4,
  parameter int K2           = 6,
  parameter int SHIFT        = 4,
  parameter int READ_LATENCY = 1
) (
  input logic                      clk,
  input logic                      reset,
  gaussian_blur_separable_if.slave bus
);
  localparam int AW   = XBITS + YBITS;
  localparam int ACCW = 10 + SHIFT + 3;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_FINISH} state_t;

  state_t           r_state;
  logic [XBITS-1:0] r_x;
  logic [YBITS-1:0] r_y;
  logic [2:0]       r_tap;
  logic [1:0]       r_wait;
  logic             r_last;
  logic             r_dir;
  logic             r_gray;
  logic [1:0]       r_chan;
  logic             r_busy;
  logic             r_done;
  logic             r_we;
  logic [AW-1:0]    r_raddr;
  logic [AW-1:0]    r_waddr;
  logic [35:0]      r_wdata;
  logic [35:0]      r_centre;
  logic [ACCW-1:0]  r_acc;
  logic             r_iss_v;
  logic [2:0]       r_iss_tap;
  logic [READ_LATENCY-1:0] r_pv;
  logic [2:0]       r_pt [READ_LATENCY];

  logic             w_ret_v;
  logic [2:0]       w_ret_tap;
  logic [2:0]       w_tap_nx;
  logic [9:0]       w_field;
  logic [ACCW-1:0]  w_acc_next;
  logic [ACCW:0]    w_rnd;
  logic [ACCW:0]    w_shf;
  logic [9:0]       w_res;
  logic [35:0]      w_wdata;
  logic             w_unused;

  function automatic int f_coef(input logic [2:0] k);
    case (k)
      3'd0, 3'd4: return K0;
      3'd1, 3'd3: return K1;
      default:    return K2;
    endcase
  endfunction

  function automatic logic [AW-1:0] f_addr(input logic [XBITS-1:0] x, input logic [YBITS-1:0] y,
                                           input logic [2:0] k, input logic dir);
    int cx;
    int cy;
    cx = int'(x);
    cy = int'(y);
    if (dir) cy = cy + int'(k) - 2;
    else     cx = cx + int'(k) - 2;
    if (cx < 0) cx = 0;
    else if (cx > WIDTH - 1) cx = WIDTH - 1;
    if (cy < 0) cy = 0;
    else if (cy > HEIGHT - 1) cy = HEIGHT - 1;
    return AW'(cy * (2 ** XBITS) + cx);
  endfunction

  // Tap tags travel alongside the memory pipeline so only data from taps of the current frame is used.
  assign w_ret_v    = r_pv[READ_LATENCY-1];
  assign w_ret_tap  = r_pt[READ_LATENCY-1];
  assign w_tap_nx   = r_tap + 3'd1;
  assign w_acc_next = r_acc + (w_ret_v ? ACCW'(f_coef(w_ret_tap) * int'(w_field)) : '0);
  assign w_rnd      = {1'b0, w_acc_next} + (ACCW+1)'(2 ** (SHIFT - 1));
  assign w_shf      = w_rnd >> SHIFT;
  assign w_res      = (w_shf > (ACCW+1)'(1023)) ? 10'd1023 : w_shf[9:0];
  assign w_unused   = ^{bus.read_data[35:30], r_centre[35:30]};

  always_comb begin
    case (r_chan)
      2'd1:    w_field = bus.read_data[19:10];
      2'd2:    w_field = bus.read_data[9:0];
      default: w_field = bus.read_data[29:20];
    endcase
  end

  always_comb begin
    w_wdata        = '0;
    w_wdata[29:20] = r_gray ? 10'd512 : r_centre[29:20];
    w_wdata[19:10] = r_gray ? 10'd512 : r_centre[19:10];
    w_wdata[9:0]   = r_gray ? 10'd512 : r_centre[9:0];
    case (r_chan)
      2'd1:    w_wdata[19:10] = w_res;
      2'd2:    w_wdata[9:0]   = w_res;
      default: w_wdata[29:20] = w_res;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_tap     <= '0;
      r_wait    <= '0;
      r_last    <= 1'b0;
      r_dir     <= 1'b0;
      r_gray    <= 1'b0;
      r_chan    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_we      <= 1'b0;
      r_raddr   <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_centre  <= '0;
      r_acc     <= '0;
      r_iss_v   <= 1'b0;
      r_iss_tap <= '0;
      r_pv      <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) r_pt[i] <= '0;
    end else begin
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_iss_v   <= 1'b0;
      r_acc     <= w_acc_next;
      r_pv[0]   <= r_iss_v;
      r_pt[0]   <= r_iss_tap;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pt[i] <= r_pt[i-1];
      end
      if (w_ret_v && w_ret_tap == 3'd2) r_centre <= bus.read_data;

      if (bus.start) begin
        // A restart flushes every in-flight tag so late data from the abandoned pixel is dropped.
        r_dir     <= bus.direction;
        r_chan    <= bus.channel;
        r_gray    <= bus.gray;
        r_x       <= '0;
        r_y       <= '0;
        r_last    <= 1'b0;
        r_busy    <= 1'b1;
        r_state   <= S_READ;
        r_tap     <= '0;
        r_raddr   <= f_addr('0, '0, 3'd0, bus.direction);
        r_iss_v   <= 1'b1;
        r_iss_tap <= 3'd0;
        r_acc     <= '0;
        r_pv      <= '0;
      end else begin
        case (r_state)
          S_READ: begin
            if (r_tap == 3'd4) begin
              r_state <= S_WAIT;
              r_wait  <= '0;
            end else begin
              r_tap     <= w_tap_nx;
              r_raddr   <= f_addr(r_x, r_y, w_tap_nx, r_dir);
              r_iss_v   <= 1'b1;
              r_iss_tap <= w_tap_nx;
            end
          end
          S_WAIT: begin
            if (r_wait == 2'(READ_LATENCY - 1)) begin
              r_state <= S_WRITE;
              r_we    <= 1'b1;
              r_waddr <= {r_y, r_x};
              r_wdata <= w_wdata;
              r_last  <= (r_x == XBITS'(WIDTH - 1)) && (r_y == YBITS'(HEIGHT - 1));
              if (r_x == XBITS'(WIDTH - 1)) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
              end else begin
                r_x <= r_x + 1'b1;
              end
            end else begin
              r_wait <= r_wait + 2'd1;
            end
          end
          S_WRITE: begin
            if (r_last) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_READ;
              r_tap     <= '0;
              r_raddr   <= f_addr(r_x, r_y, 3'd0, r_dir);
              r_iss_v   <= 1'b1;
              r_iss_tap <= 3'd0;
              r_acc     <= '0;
            end
          end
          S_FINISH: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.read_addr    = r_raddr;
  assign bus.write_addr   = r_waddr;
  assign bus.write_data   = r_wdata;
  assign bus.write_enable = r_we;

endmodule

// File: tb/tb_gaussian_blur_separable.sv
// Randomised and directed frames on three engine instances (read latency 1, 2, 3) against a pixel-level model.
module tb_gaussian_blur_separable;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int XB = 4;
  localparam int YB = 3;
  localparam int AW = XB + YB;
  localparam int XS = 1 << XB;

  typedef struct {
    int          cyc;
    int          addr;
    logic [35:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [35:0] mem [1 << AW];

  gaussian_blur_separable_if #(.AW(AW)) if0 ();
  gaussian_blur_separable_if #(.AW(AW)) if1 ();
  gaussian_blur_separable_if #(.AW(AW)) if2 ();

  gaussian_blur_separable #(.WIDTH(W), .HEIGHT(H), .XBITS(XB), .YBITS(YB), .READ_LATENCY(1))
    u_dut0 (.clk(clk), .reset(rst), .bus(if0));
  gaussian_blur_separable #(.WIDTH(W), .HEIGHT(H), .XBITS(XB), .YBITS(YB), .READ_LATENCY(2))
    u_dut1 (.clk(clk), .reset(rst), .bus(if1));
  gaussian_blur_separable #(.WIDTH(W), .HEIGHT(H), .XBITS(XB), .YBITS(YB), .READ_LATENCY(3))
    u_dut2 (.clk(clk), .reset(rst), .bus(if2));

  // Synchronous memories with 1, 2 and 3 cycles of read latency.
  logic [35:0] p1a, p2a, p2b;
  always @(posedge clk) begin
    if0.read_data <= mem[if0.read_addr];
    p1a           <= mem[if1.read_addr];
    if1.read_data <= p1a;
    p2a           <= mem[if2.read_addr];
    p2b           <= p2a;
    if2.read_data <= p2b;
  end

  wr_t wq0[$], wq1[$], wq2[$];
  int  dq0[$], dq1[$], dq2[$];

  always @(negedge clk) begin
    wr_t w;
    if (if0.write_enable) begin w.cyc = cyc; w.addr = int'(if0.write_addr); w.data = if0.write_data; wq0.push_back(w); end
    if (if1.write_enable) begin w.cyc = cyc; w.addr = int'(if1.write_addr); w.data = if1.write_data; wq1.push_back(w); end
    if (if2.write_enable) begin w.cyc = cyc; w.addr = int'(if2.write_addr); w.data = if2.write_data; wq2.push_back(w); end
    if (if0.done) dq0.push_back(cyc);
    if (if1.done) dq1.push_back(cyc);
    if (if2.done) dq2.push_back(cyc);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] rand36();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[35:0];
  endfunction

  function automatic int fld(input logic [35:0] w, input int i);
    logic [35:0] s;
    s = w >> (20 - 10 * i);
    return int'(s[9:0]);
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [35:0] model_px(input int x, input int y, input bit dir,
                                           input logic [1:0] ch, input bit g);
    int kern [5] = '{1, 4, 6, 4, 1};
    int sel, acc, res, tx, ty;
    logic [35:0] c, r;
    sel = (ch == 2'd3) ? 0 : int'(ch);
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      tx = dir ? x : clampi(x + k - 2, W - 1);
      ty = dir ? clampi(y + k - 2, H - 1) : y;
      acc += kern[k] * fld(mem[ty * XS + tx], sel);
    end
    res = (acc + 8) / 16;
    if (res > 1023) res = 1023;
    c = mem[y * XS + x];
    r = '0;
    for (int i = 0; i < 3; i++) begin
      int v;
      v = (i == sel) ? res : (g ? 512 : fld(c, i));
      r = r | (36'(v) << (20 - 10 * i));
    end
    return r;
  endfunction

  task automatic set_ctrl(input int d, input logic s, input logic dir, input logic [1:0] ch, input logic g);
    case (d)
      0:       begin if0.start = s; if0.direction = dir; if0.channel = ch; if0.gray = g; end
      1:       begin if1.start = s; if1.direction = dir; if1.channel = ch; if1.gray = g; end
      default: begin if2.start = s; if2.direction = dir; if2.channel = ch; if2.gray = g; end
    endcase
  endtask

  task automatic clear_q(input int d);
    case (d)
      0:       begin wq0.delete(); dq0.delete(); end
      1:       begin wq1.delete(); dq1.delete(); end
      default: begin wq2.delete(); dq2.delete(); end
    endcase
  endtask

  function automatic logic get_busy(input int d);
    case (d)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  function automatic int n_done(input int d);
    case (d)
      0:       return dq0.size();
      1:       return dq1.size();
      default: return dq2.size();
    endcase
  endfunction

  // Modes are scrambled right after the start cycle; the engine must keep the sampled ones.
  task automatic start_frame(input int d, input bit dir, input logic [1:0] ch, input bit g, output int n0);
    @(negedge clk);
    set_ctrl(d, 1'b1, dir, ch, g);
    @(posedge clk);
    #1;
    clear_q(d);
    n0 = cyc;
    set_ctrl(d, 1'b0, ~dir, ~ch, ~g);
  endtask

  task automatic wait_done(input int d, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      #1;
      if (n_done(d) > 0) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("busy_in_finish", get_busy(d), 1);
      @(negedge clk);
      #1;
      check("busy_after", get_busy(d), 0);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic verify(input int d, input int n0, input bit dir, input logic [1:0] ch, input bit g);
    wr_t q[$];
    int  dq[$];
    int  lat;
    lat = d + 1;
    case (d)
      0:       begin q = wq0; dq = dq0; end
      1:       begin q = wq1; dq = dq1; end
      default: begin q = wq2; dq = dq2; end
    endcase
    check("n_writes", q.size(), W * H);
    foreach (q[i]) begin
      int x = i % W;
      int y = i / W;
      check("waddr", q[i].addr, y * XS + x);
      check("wdata", q[i].data, model_px(x, y, dir, ch, g));
      if (i == 0) check("first_latency", q[i].cyc - n0, 5 + lat);
      else        check("write_period", q[i].cyc - q[i-1].cyc, 6 + lat);
    end
    check("n_done", dq.size(), 1);
    if (q.size() > 0 && dq.size() > 0) check("done_lag", dq[0] - q[q.size()-1].cyc, 1);
  endtask

  task automatic run_frame(input int d, input bit dir, input logic [1:0] ch, input bit g);
    int n0;
    start_frame(d, dir, ch, g, n0);
    wait_done(d, 1500);
    verify(d, n0, dir, ch, g);
  endtask

  task automatic fill_random();
    for (int i = 0; i < (1 << AW); i++) mem[i] = rand36();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, k;
    int himp [5] = '{64, 256, 384, 256, 64};
    int vimp [4] = '{256, 384, 256, 64};
    for (int d = 0; d < 3; d++) set_ctrl(d, 1'b0, 1'b0, 2'd0, 1'b0);
    fill_random();

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", if0.busy, 0);
    check("rst_done", if0.done, 0);
    check("rst_we", if0.write_enable, 0);
    check("rst_raddr", if0.read_addr, 0);
    check("rst_waddr", if0.write_addr, 0);
    check("rst_wdata", if0.write_data, 0);

    // Constant channel-0 frame.
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = rand36();
      mem[i][29:20] = 10'd100;
    end
    run_frame(0, 1'b0, 2'd0, 1'b1);
    if (wq0.size() == W * H) begin
      check("const_first", wq0[0].data, {6'b0, 10'd100, 10'd512, 10'd512});
      check("const_last", wq0[W*H-1].data, {6'b0, 10'd100, 10'd512, 10'd512});
    end

    // Impulse at (3,1), horizontal then vertical.
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = rand36();
      mem[i][29:20] = 10'd0;
    end
    mem[1 * XS + 3][29:20] = 10'd1023;
    run_frame(0, 1'b0, 2'd0, 1'b1);
    if (wq0.size() == W * H) begin
      for (int x = 1; x <= 5; x++) check("h_impulse", wq0[W + x].data[29:20], himp[x-1]);
      check("h_impulse_off", wq0[W + 6].data[29:20], 0);
    end
    run_frame(0, 1'b1, 2'd0, 1'b1);
    if (wq0.size() == W * H) begin
      for (int y = 0; y < 4; y++) check("v_impulse", wq0[y * W + 3].data[29:20], vimp[y]);
      check("v_impulse_off", wq0[W + 2].data[29:20], 0);
    end

    // Left-edge clamp on a channel-1 ramp with pass-through.
    fill_random();
    for (int x = 0; x < W; x++) mem[x][19:10] = 10'(16 * x);
    run_frame(0, 1'b0, 2'd1, 1'b0);
    if (wq0.size() == W * H) begin
      check("edge_f1", wq0[0].data[19:10], 6);
      check("edge_f0", wq0[0].data[29:20], mem[0][29:20]);
      check("edge_f2", wq0[0].data[9:0], mem[0][9:0]);
      check("edge_top", wq0[0].data[35:30], 0);
    end

    // Random frames at every read latency.
    for (int r = 0; r < 7; r++) begin
      fill_random();
      run_frame(r % 3, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset after 10 writes.
    fill_random();
    start_frame(0, 1'b0, 2'd0, 1'b1, n0);
    k = 0;
    while (wq0.size() < 10 && k < 1000) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("rst_reach10", int'(wq0.size() >= 10), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_q(0);
    @(negedge clk);
    check("midrst_busy", if0.busy, 0);
    check("midrst_we", if0.write_enable, 0);
    check("midrst_done", if0.done, 0);
    repeat (300) @(negedge clk);
    #1;
    check("midrst_nwr", wq0.size(), 0);
    check("midrst_ndone", dq0.size(), 0);

    // Reset and start in the same cycle.
    @(negedge clk);
    rst = 1'b1;
    set_ctrl(0, 1'b1, 1'b0, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_ctrl(0, 1'b0, 1'b0, 2'd0, 1'b0);
    clear_q(0);
    @(negedge clk);
    check("rst_prio_busy", if0.busy, 0);
    repeat (100) @(negedge clk);
    #1;
    check("rst_prio_nwr", wq0.size(), 0);

    // Restart mid-pixel with new modes.
    for (int r = 0; r < 2; r++) begin
      fill_random();
      start_frame(0, 1'b0, 2'd0, 1'b1, n0);
      k = 0;
      while (wq0.size() < 5 && k < 1000) begin
        @(negedge clk);
        #1;
        k++;
      end
      check("restart_reach5", int'(wq0.size() >= 5), 1);
      repeat ($urandom_range(0, 6)) @(negedge clk);
      start_frame(0, 1'b1, 2'(r + 1), 1'b0, n0);
      wait_done(0, 1500);
      verify(0, n0, 1'b1, 2'(r + 1), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
